// File: rtl/countdown_digit_timer.sv
// rtl/countdown_digit_timer.sv - single-digit seconds countdown for the HUD "Ns" text ROM
//
// Purpose:
//   Divides i_clk into 1 s ticks and counts a single decimal digit down to 0
//   under a start/pause/load state machine. The displayed digit only updates
//   on i_frame_start, so the HUD never shows a torn digit mid-frame.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        pulse: start from IDLE or resume from PAUSE
//   i_pause        pulse: suspend a running count
//   i_load         pulse: reload the count from i_load_val (highest priority)
//   i_load_val     reload value, values above 9 clamp to 9
//   i_frame_start  pulse at the first pixel of each frame
//   o_digit        displayed seconds 0..9 (text ROM digit input)
//   o_running      high in RUN
//   o_expired      high in DONE
//   o_expire_pulse one-cycle pulse on entry to DONE
//   o_warn         high in RUN or PAUSE while the count is 1..3

module countdown_digit_timer #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int START_SEC   = 9
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_frame_start,
  output logic [3:0] o_digit,
  output logic       o_running,
  output logic       o_expired,
  output logic       o_expire_pulse,
  output logic       o_warn
);

  localparam int            PW         = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [3:0]    START_VAL  = 4'(START_SEC);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic [3:0]    r_count;
  logic [3:0]    w_count_nx;
  logic [PW-1:0] r_presc;
  logic [PW-1:0] w_presc_nx;
  logic          w_tick;
  logic          w_pulse_nx;
  logic          w_warn_nx;
  logic [3:0]    w_load_clamped;

  assign w_tick         = (r_state == S_RUN) && (r_presc == PRESC_LAST);
  assign w_load_clamped = (i_load_val > 4'd9) ? 4'd9 : i_load_val;

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    w_presc_nx = r_presc;
    w_pulse_nx = 1'b0;

    if (i_load) begin
      // load wins over any pause/start presented on the same edge
      w_state_nx = S_IDLE;
      w_count_nx = w_load_clamped;
      w_presc_nx = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc_nx = '0;
          if (i_start) begin
            if (r_count != 4'd0) begin
              w_state_nx = S_RUN;
            end else begin
              w_state_nx = S_DONE;
              w_pulse_nx = 1'b1;
            end
          end
        end

        S_RUN: begin
          if (i_pause) begin
            // A tick landing on the pause edge is deferred: the prescaler
            // parks at its last value so the first RUN cycle after resume ticks.
            w_state_nx = S_PAUSE;
            if (!w_tick) begin
              w_presc_nx = r_presc + PW'(1);
            end
          end else if (w_tick) begin
            w_presc_nx = '0;
            if (r_count != 4'd0) begin
              w_count_nx = r_count - 4'd1;
            end
            if (r_count <= 4'd1) begin
              w_state_nx = S_DONE;
              w_pulse_nx = 1'b1;
            end
          end else begin
            w_presc_nx = r_presc + PW'(1);
          end
        end

        S_PAUSE: begin
          if (i_start) begin
            w_state_nx = S_RUN;
          end
        end

        S_DONE: begin
          w_count_nx = 4'd0;
        end

        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  assign w_warn_nx = ((w_state_nx == S_RUN) || (w_state_nx == S_PAUSE)) &&
                     (w_count_nx != 4'd0) && (w_count_nx <= 4'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_count        <= START_VAL;
      r_presc        <= '0;
      o_digit        <= START_VAL;
      o_running      <= 1'b0;
      o_expired      <= 1'b0;
      o_expire_pulse <= 1'b0;
      o_warn         <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_count        <= w_count_nx;
      r_presc        <= w_presc_nx;
      o_running      <= (w_state_nx == S_RUN);
      o_expired      <= (w_state_nx == S_DONE);
      o_expire_pulse <= w_pulse_nx;
      o_warn         <= w_warn_nx;
      // sample the count being written this edge so the frame sees the freshest value
      if (i_frame_start) begin
        o_digit <= w_count_nx;
      end
    end
  end

endmodule

// File: tb/tb_countdown_digit_timer.sv
// tb/tb_countdown_digit_timer.sv - scoreboard bench for countdown_digit_timer
module tb_countdown_digit_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       frame_start = 1'b1;
  logic [3:0] digit;
  logic       running;
  logic       expired;
  logic       expire_pulse;
  logic       warn;

  countdown_digit_timer #(
    .TICK_CYCLES(4),
    .START_SEC  (3)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_pause       (pause),
    .i_load        (load),
    .i_load_val    (load_val),
    .i_frame_start (frame_start),
    .o_digit       (digit),
    .o_running     (running),
    .o_expired     (expired),
    .o_expire_pulse(expire_pulse),
    .o_warn        (warn)
  );

  typedef struct {
    int         cyc;
    logic [3:0] e_digit;
    logic       e_run;
    logic       e_exp;
    logic       e_warn;
    logic       e_pulse;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   base = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk1(input string name, input string field, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s %s: got %0d expected %0d (cycle %0d)", name, field, got, want, cyc);
    end
  endtask

  task automatic chk_rec(input exp_t e);
    chk1(e.name, "digit", int'(digit), int'(e.e_digit));
    chk1(e.name, "running", int'(running), int'(e.e_run));
    chk1(e.name, "expired", int'(expired), int'(e.e_exp));
    chk1(e.name, "warn", int'(warn), int'(e.e_warn));
    chk1(e.name, "expire_pulse", int'(expire_pulse), int'(e.e_pulse));
  endtask

  function automatic void ex(input int k, input logic [3:0] d, input logic r, input logic e,
                             input logic w, input logic p, input string nm);
    exp_t t;
    t.cyc = base + k; t.e_digit = d; t.e_run = r; t.e_exp = e; t.e_warn = w; t.e_pulse = p;
    t.name = nm;
    sb.push_back(t);
  endfunction

  // Monitor: every falling edge, retire all expectations due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        if (sb[i].cyc < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s missed: due cycle %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        end else begin
          chk_rec(sb[i]);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    // ---- reset, then start from START_SEC=3
    @(negedge clk);
    base = cyc; ex(1, 4'd3, 0, 0, 0, 0, "in_reset"); step();
    rst_n = 1'b1;
    base = cyc; ex(1, 4'd3, 0, 0, 0, 0, "idle_after_reset"); step();

    base = cyc;
    ex(1,  4'd3, 1, 0, 1, 0, "start_run");
    ex(4,  4'd3, 1, 0, 1, 0, "before_tick1");
    ex(5,  4'd2, 1, 0, 1, 0, "tick1");
    ex(8,  4'd2, 1, 0, 1, 0, "before_tick2");
    ex(9,  4'd1, 1, 0, 1, 0, "tick2");
    ex(12, 4'd1, 1, 0, 1, 0, "before_tick3");
    ex(13, 4'd0, 0, 1, 0, 1, "expire");
    ex(14, 4'd0, 0, 1, 0, 0, "expire_one_cycle");
    start = 1'b1; step(); start = 1'b0;
    repeat (13) step();

    // ---- DONE ignores start and pause over 50 random cycles
    base = cyc;
    for (int i = 1; i <= 50; i++) ex(i, 4'd0, 0, 1, 0, 0, "done_ignore");
    for (int i = 1; i <= 50; i++) begin
      start = 1'($urandom_range(0, 1));
      pause = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0; pause = 1'b0;

    // ---- load 0 then start: immediate DONE with a single pulse
    base = cyc;
    ex(1, 4'd0, 0, 0, 0, 0, "load0_idle");
    ex(2, 4'd0, 0, 1, 0, 1, "load0_start_done");
    ex(3, 4'd0, 0, 1, 0, 0, "load0_single_pulse");
    ex(4, 4'd0, 0, 1, 0, 0, "load0_single_pulse2");
    load = 1'b1; load_val = 4'd0; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step(); step();

    // ---- pause ignored in IDLE and PAUSE; prescaler position preserved
    base = cyc;
    for (int i = 1; i <= 32; i++) begin
      if (i <= 11)      ex(i, 4'd2, 0, 0, 0, 0, "idle_pause_ignored");
      else if (i <= 15) ex(i, 4'd2, 1, 0, 1, 0, "run2");
      else if (i == 16) ex(i, 4'd1, 1, 0, 1, 0, "run2_tick");
      else if (i <= 27) ex(i, 4'd1, 0, 0, 1, 0, "pause_pause_ignored");
      else if (i <= 30) ex(i, 4'd1, 1, 0, 1, 0, "resume_held_presc");
      else if (i == 31) ex(i, 4'd0, 0, 1, 0, 1, "resume_expire");
      else              ex(i, 4'd0, 0, 1, 0, 0, "resume_expired");
    end
    for (int i = 1; i <= 32; i++) begin
      load = (i == 1); load_val = 4'd2;
      start = (i == 12) || (i == 28);
      if ((i >= 2 && i <= 11) || (i >= 18 && i <= 27)) pause = 1'($urandom_range(0, 1));
      else pause = (i == 17);
      step();
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;

    // ---- pause/resume, pause on tick edge, start ignored in RUN/DONE
    base = cyc;
    ex(1, 4'd3, 0, 0, 0, 0, "pr_load3");
    for (int k = 1; k <= 40; k++) begin
      if (k <= 2)       ex(k + 1, 4'd3, 1, 0, 1, 0, "pr_run");
      else if (k <= 23) ex(k + 1, 4'd3, 0, 0, 1, 0, "pr_paused_hold");
      else if (k <= 25) ex(k + 1, 4'd3, 1, 0, 1, 0, "pr_resumed");
      else if (k <= 29) ex(k + 1, 4'd2, 1, 0, 1, 0, "pr_tick_2_after_resume");
      else if (k <= 32) ex(k + 1, 4'd2, 0, 0, 1, 0, "pr_pause_on_tick");
      else if (k == 33) ex(k + 1, 4'd2, 1, 0, 1, 0, "pr_resume_at_last");
      else if (k <= 37) ex(k + 1, 4'd1, 1, 0, 1, 0, "pr_tick_first_cycle");
      else if (k == 38) ex(k + 1, 4'd0, 0, 1, 0, 1, "pr_expire");
      else              ex(k + 1, 4'd0, 0, 1, 0, 0, "pr_done");
    end
    for (int i = 1; i <= 41; i++) begin
      load = (i == 1); load_val = 4'd3;
      start = (i - 1 == 1) || (i - 1 == 24) || (i - 1 == 33) || (i - 1 == 35) ||
              (i - 1 == 36) || (i - 1 == 37) || (i - 1 == 39);
      pause = (i - 1 == 3) || (i - 1 == 30) || (i - 1 == 40);
      step();
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;

    // ---- load 12 in RUN with pause and start: clamp to 9, back to IDLE
    base = cyc;
    ex(1, 4'd3, 0, 0, 0, 0, "prio_load3");
    ex(2, 4'd3, 1, 0, 1, 0, "prio_run");
    ex(3, 4'd3, 1, 0, 1, 0, "prio_run2");
    ex(4, 4'd9, 0, 0, 0, 0, "prio_load_clamp");
    ex(5, 4'd9, 0, 0, 0, 0, "prio_idle_hold");
    load = 1'b1; load_val = 4'd3; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    load = 1'b1; load_val = 4'd12; pause = 1'b1; start = 1'b1; step();
    load = 1'b0; pause = 1'b0; start = 1'b0;
    step();

    // ---- frame-gated display, frame_start every 10 cycles
    base = cyc;
    ex(1, 4'd9, 0, 0, 0, 0, "fr_load9");
    ex(2, 4'd9, 1, 0, 0, 0, "fr_start");
    ex(10, 4'd9, 1, 0, 0, 0, "fr_hold9");
    ex(11, 4'd7, 1, 0, 0, 0, "fr_show7");
    ex(20, 4'd7, 1, 0, 0, 0, "fr_hold7");
    ex(21, 4'd5, 1, 0, 0, 0, "fr_show5");
    ex(26, 4'd5, 1, 0, 1, 0, "fr_warn_hidden");
    ex(30, 4'd5, 1, 0, 1, 0, "fr_hold5");
    ex(31, 4'd2, 1, 0, 1, 0, "fr_show2");
    ex(38, 4'd2, 0, 1, 0, 1, "fr_expire_digit_held");
    ex(39, 4'd2, 0, 1, 0, 0, "fr_done_held");
    ex(41, 4'd0, 0, 1, 0, 0, "fr_show0");
    load = 1'b1; load_val = 4'd9; frame_start = 1'b1; step(); load = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      start = (k == 1);
      frame_start = (k % 10 == 0);
      step();
    end
    start = 1'b0; frame_start = 1'b1;

    // ---- asynchronous reset one cycle before expiry
    base = cyc;
    ex(1, 4'd1, 0, 0, 0, 0, "ar_load1");
    for (int k = 2; k <= 5; k++) ex(k, 4'd1, 1, 0, 1, 0, "ar_run");
    load = 1'b1; load_val = 4'd1; step(); load = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk1("async_reset", "digit", int'(digit), 3);
    chk1("async_reset", "running", int'(running), 0);
    chk1("async_reset", "expired", int'(expired), 0);
    chk1("async_reset", "warn", int'(warn), 0);
    chk1("async_reset", "expire_pulse", int'(expire_pulse), 0);
    @(negedge clk);
    base = cyc; ex(1, 4'd3, 0, 0, 0, 0, "ar_held"); step();
    rst_n = 1'b1;
    base = cyc;
    for (int k = 1; k <= 8; k++) ex(k, 4'd3, 0, 0, 0, 0, "ar_no_pulse_after");
    repeat (8) step();

    // ---- drain the scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() != 0; i++) step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
